// File: rtl/pcpi_mul_arbiter.sv
// Round-robin arbiter sharing one PCPI multiplier between NUM_REQ PCPI masters.
// Operands are latched at grant; the result is returned as a one-cycle req_ready pulse.
module pcpi_mul_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FILTER_MUL = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_insn,
  input  logic [32*NUM_REQ-1:0]  req_rs1,
  input  logic [32*NUM_REQ-1:0]  req_rs2,
  output logic [NUM_REQ-1:0]     req_wr,
  output logic [31:0]            req_rd,
  output logic [NUM_REQ-1:0]     req_wait,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   m_valid,
  output logic [31:0]            m_insn,
  output logic [31:0]            m_rs1,
  output logic [31:0]            m_rs2,
  input  logic                   m_wr,
  input  logic                   m_wait,
  input  logic                   m_ready,
  input  logic [31:0]            m_rd
);

  localparam int          GW    = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [31:0] TLAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [31:0]         m_insn_q, m_insn_d;
  logic [31:0]         m_rs1_q, m_rs1_d;
  logic [31:0]         m_rs2_q, m_rs2_d;
  logic [31:0]         rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [NUM_REQ-1:0]  blocked_q, blocked_d;
  logic [31:0]         timer_q, timer_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                any_elig;
  logic [GW-1:0]       pick;
  logic [31:0]         sel_insn, sel_rs1, sel_rs2;

  // Only MUL/MULH/MULHSU/MULHU (funct3[2]=0) are considered when filtering.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    logic is_mul;
    assign is_mul = (req_insn[32*gi +: 7] == 7'b0110011) &&
                    (req_insn[32*gi+25 +: 7] == 7'b0000001) &&
                    !req_insn[32*gi+14];
    assign eligible[gi] = req_valid[gi] & ~blocked_q[gi] & ((FILTER_MUL == 0) || is_mul);
  end

  // Search from last_q+1; walking k downwards lets the nearest candidate win.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    any_elig = 1'b0;
    sel_insn = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && eligible[i]) begin
          pick     = GW'(i);
          any_elig = 1'b1;
          sel_insn = req_insn[32*i +: 32];
          sel_rs1  = req_rs1[32*i +: 32];
          sel_rs2  = req_rs2[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_insn_d  = m_insn_q;
    m_rs1_d   = m_rs1_q;
    m_rs2_d   = m_rs2_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    timer_d   = timer_q;
    blocked_d = blocked_q & req_valid;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          grant_d  = pick;
          last_d   = pick;
          m_insn_d = sel_insn;
          m_rs1_d  = sel_rs1;
          m_rs2_d  = sel_rs2;
          timer_d  = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          rd_d               = m_rd;
          wr_d               = m_wr;
          blocked_d[grant_q] = 1'b1;
          state_d            = DONE;
        end else if (!req_valid[grant_q]) begin
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST) && !m_wait) begin
          // Blocking drops req_wait so the core's own PCPI timeout fires.
          blocked_d[grant_q] = 1'b1;
          state_d            = IDLE;
        end else begin
          timer_d = m_wait ? '0 : timer_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      m_insn_q  <= '0;
      m_rs1_q   <= '0;
      m_rs2_q   <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      blocked_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_insn_q  <= m_insn_d;
      m_rs1_q   <= m_rs1_d;
      m_rs2_q   <= m_rs2_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      blocked_q <= blocked_d;
      timer_q   <= timer_d;
    end
  end

  logic [NUM_REQ-1:0] grant_onehot;
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  assign m_valid   = (state_q == ISSUE);
  assign m_insn    = m_insn_q;
  assign m_rs1     = m_rs1_q;
  assign m_rs2     = m_rs2_q;
  assign req_wait  = eligible;
  assign req_ready = (state_q == DONE) ? grant_onehot : '0;
  assign req_wr    = wr_q ? req_ready : '0;
  assign req_rd    = (state_q == DONE) ? rd_q : '0;

endmodule
